// File: rtl/rv_dsp_pkg.sv
// Shared types and constants for the execute/write-back datapath.
package rv_dsp_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/wb_sync_fifo.sv
// In-order result buffer; exposes every slot and its valid bit so the
// owner can search for outstanding destination registers.
module wb_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] entries [DEPTH],
    output logic [DEPTH-1:0] valid
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    // Extra wrap bit distinguishes full from empty when the indices coincide.
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        if (push_ok) begin
            wr_ptr_d                   = wr_ptr_q + (PW+1)'(1);
            vld_d[wr_ptr_q[PW-1:0]]    = 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d                   = rd_ptr_q + (PW+1)'(1);
            vld_d[rd_ptr_q[PW-1:0]]    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q[PW-1:0]];
    assign entries  = mem_q;
    assign valid    = vld_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges single-cycle ALU results and buffered DSP results onto the
// register file's single write port, and reports pending writes for hazard stalls.
module regfile_wb_arbiter
    import rv_dsp_pkg::*;
#(
    parameter int DATA_W         = XLEN,
    parameter int ADDR_W         = REG_ADDR_W,
    parameter int DSP_FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              dsp_valid,
    output logic              dsp_ready,
    input  logic [ADDR_W-1:0] dsp_rd,
    input  logic [DATA_W-1:0] dsp_data,
    input  logic [ADDR_W-1:0] q_rs1,
    input  logic [ADDR_W-1:0] q_rs2,
    output logic              pend_rs1,
    output logic              pend_rs2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);
    localparam int ENTRY_W = $bits(wb_entry_t);

    logic                      fifo_full, fifo_empty;
    logic                      alu_fire, dsp_push, fifo_pop;
    wb_entry_t                 push_entry, head_entry;
    logic [ENTRY_W-1:0]        head_raw;
    logic [ENTRY_W-1:0]        fifo_entries [DSP_FIFO_DEPTH];
    logic [DSP_FIFO_DEPTH-1:0] fifo_valid;

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    function automatic logic pending(
        input logic [ADDR_W-1:0]        q,
        input logic [ENTRY_W-1:0]       ent [DSP_FIFO_DEPTH],
        input logic [DSP_FIFO_DEPTH-1:0] vld,
        input logic                     out_we,
        input logic [ADDR_W-1:0]        out_addr
    );
        wb_entry_t e;
        logic      hit;
        hit = out_we && (out_addr == q);
        for (int i = 0; i < DSP_FIFO_DEPTH; i++) begin
            e = wb_entry_t'(ent[i]);
            if (vld[i] && (e.rd == q)) hit = 1'b1;
        end
        return hit && (q != REG_X0);
    endfunction

    // A full buffer stalls the ALU too, otherwise the DSP head could starve.
    assign alu_ready = !rst && !fifo_full;
    assign dsp_ready = !rst && !fifo_full;

    assign alu_fire = alu_valid && alu_ready;
    assign dsp_push = dsp_valid && dsp_ready && (dsp_rd != REG_X0);
    assign fifo_pop = !alu_fire && !fifo_empty;

    assign push_entry.rd   = dsp_rd;
    assign push_entry.data = dsp_data;
    assign head_entry      = wb_entry_t'(head_raw);

    wb_sync_fifo #(
        .DEPTH (DSP_FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_dsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (dsp_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .entries   (fifo_entries),
        .valid     (fifo_valid)
    );

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (alu_fire) begin
            if (alu_rd != REG_X0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = alu_rd;
                rf_wdata_d = alu_data;
            end
        end else if (!fifo_empty) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head_entry.rd;
            rf_wdata_d = head_entry.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    assign pend_rs1 = !rst && pending(q_rs1, fifo_entries, fifo_valid, rf_we_q, rf_waddr_q);
    assign pend_rs2 = !rst && pending(q_rs2, fifo_entries, fifo_valid, rf_we_q, rf_waddr_q);
endmodule
